rca_config_bank: RTL

Multi-RCA, double-buffered configuration store for the reconfigurable custom accelerator (RCA) path. Decode/issue sends RCA config instructions (CPU register, grid mux, IO mux, result mux and IO-use writes) into a per-RCA shadow bank. An explicit commit copies the shadow bank atomically into the active bank that drives the grid and the register-address lookup. A commit aimed at an RCA that is currently executing is held pending and applied when that RCA goes idle, so reconfiguration can overlap execution.

---
 rtl/rca_config_bank.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/rca_config_bank.sv
// Double-buffered per-RCA configuration store: decode/issue writes fields into a shadow bank,
// and a commit copies that bank into the active bank, deferred while the target RCA is busy.
module rca_config_bank #(
  parameter int NUM_RCAS        = 3,
  parameter int NUM_READ_PORTS  = 5,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int NUM_GRID_MUXES  = 16,
  parameter int GRID_MUX_SEL_W  = 3,
  parameter int GRID_NUM_ROWS   = 4,
  parameter int IO_MUX_SEL_W    = 3,
  localparam int RCA_SEL_W      = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1,
  localparam int RES_SEL_W      = (GRID_NUM_ROWS > 1) ? $clog2(GRID_NUM_ROWS) : 1
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 cfg_valid,
  output logic                                                 cfg_ready,
  input  logic [2:0]                                           cfg_type,
  input  logic [RCA_SEL_W-1:0]                                 cfg_rca_sel,
  input  logic [7:0]                                           cfg_addr,
  input  logic                                                 cfg_src_dest,
  input  logic [7:0]                                           cfg_data,
  input  logic [NUM_RCAS-1:0]                                  rca_busy,
  output logic [NUM_RCAS*NUM_READ_PORTS*5-1:0]                 src_reg_addrs,
  output logic [NUM_RCAS*NUM_WRITE_PORTS*5-1:0]                dest_reg_addrs,
  output logic [NUM_RCAS*NUM_GRID_MUXES*GRID_MUX_SEL_W-1:0]    grid_mux_sel,
  output logic [NUM_RCAS*GRID_NUM_ROWS*IO_MUX_SEL_W-1:0]       io_mux_sel,
  output logic [NUM_RCAS*NUM_WRITE_PORTS*RES_SEL_W-1:0]        result_mux_sel,
  output logic [NUM_RCAS*GRID_NUM_ROWS-1:0]                    io_inp_use,
  output logic [NUM_RCAS-1:0]                                  commit_pending,
  output logic                                                 cfg_error
);

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int RP_IW  = idx_w(NUM_READ_PORTS);
  localparam int WP_IW  = idx_w(NUM_WRITE_PORTS);
  localparam int GM_IW  = idx_w(NUM_GRID_MUXES);
  localparam int ROW_IW = idx_w(GRID_NUM_ROWS);

  localparam logic [7:0] RP_LIM  = 8'(NUM_READ_PORTS);
  localparam logic [7:0] WP_LIM  = 8'(NUM_WRITE_PORTS);
  localparam logic [7:0] GM_LIM  = 8'(NUM_GRID_MUXES);
  localparam logic [7:0] ROW_LIM = 8'(GRID_NUM_ROWS);
  localparam logic [RCA_SEL_W:0] RCA_LIM = (RCA_SEL_W+1)'(NUM_RCAS);

  localparam logic [2:0] T_CPU    = 3'd0;
  localparam logic [2:0] T_GRID   = 3'd1;
  localparam logic [2:0] T_IO     = 3'd2;
  localparam logic [2:0] T_RES    = 3'd3;
  localparam logic [2:0] T_USE    = 3'd4;
  localparam logic [2:0] T_COMMIT = 3'd5;

  typedef logic [NUM_RCAS-1:0][NUM_READ_PORTS-1:0][4:0]                src_bank_t;
  typedef logic [NUM_RCAS-1:0][NUM_WRITE_PORTS-1:0][4:0]               dst_bank_t;
  typedef logic [NUM_RCAS-1:0][NUM_GRID_MUXES-1:0][GRID_MUX_SEL_W-1:0] grid_bank_t;
  typedef logic [NUM_RCAS-1:0][GRID_NUM_ROWS-1:0][IO_MUX_SEL_W-1:0]    io_bank_t;
  typedef logic [NUM_RCAS-1:0][NUM_WRITE_PORTS-1:0][RES_SEL_W-1:0]     res_bank_t;
  typedef logic [NUM_RCAS-1:0][GRID_NUM_ROWS-1:0]                      use_bank_t;

  typedef enum logic {TRK_IDLE = 1'b0, TRK_PENDING = 1'b1} trk_e;

  src_bank_t  shadow_src_r,  active_src_r;
  dst_bank_t  shadow_dst_r,  active_dst_r;
  grid_bank_t shadow_grid_r, active_grid_r;
  io_bank_t   shadow_io_r,   active_io_r;
  res_bank_t  shadow_res_r,  active_res_r;
  use_bank_t  shadow_use_r,  active_use_r;

  trk_e trk_r [NUM_RCAS];

  logic [NUM_RCAS-1:0] pending_s;
  logic [NUM_RCAS-1:0] commit_hit_s;
  logic [NUM_RCAS-1:0] copy_s;
  logic                sel_ok_s;
  logic                field_ok_s;
  logic                req_ok_s;
  logic                sel_pending_s;
  logic                accept_s;
  logic                unused_s;

  logic [RP_IW-1:0]  rp_idx_s;
  logic [WP_IW-1:0]  wp_idx_s;
  logic [GM_IW-1:0]  gm_idx_s;
  logic [ROW_IW-1:0] row_idx_s;

  assign rp_idx_s  = cfg_addr[RP_IW-1:0];
  assign wp_idx_s  = cfg_addr[WP_IW-1:0];
  assign gm_idx_s  = cfg_addr[GM_IW-1:0];
  assign row_idx_s = cfg_addr[ROW_IW-1:0];

  // Data bits above the widest field are dropped by design.
  assign unused_s = ^cfg_data;

  assign cfg_ready = ~sel_pending_s;
  assign accept_s  = cfg_valid & cfg_ready;

  // Request decode: range check, per-RCA stall and commit/copy qualification.
  always_comb begin
    field_ok_s    = 1'b0;
    sel_ok_s      = ({1'b0, cfg_rca_sel} < RCA_LIM);
    sel_pending_s = 1'b0;
    for (int n = 0; n < NUM_RCAS; n++) begin
      pending_s[n] = (trk_r[n] == TRK_PENDING);
    end
    if (sel_ok_s) begin
      sel_pending_s = pending_s[cfg_rca_sel];
    end else begin
      sel_pending_s = 1'b0;
    end
    case (cfg_type)
      T_CPU:    field_ok_s = cfg_src_dest ? (cfg_addr < WP_LIM) : (cfg_addr < RP_LIM);
      T_GRID:   field_ok_s = (cfg_addr < GM_LIM);
      T_IO:     field_ok_s = (cfg_addr < ROW_LIM);
      T_RES:    field_ok_s = (cfg_addr < WP_LIM);
      T_USE:    field_ok_s = (cfg_addr < ROW_LIM);
      T_COMMIT: field_ok_s = 1'b1;
      default:  field_ok_s = 1'b0;
    endcase
    req_ok_s = sel_ok_s & field_ok_s;
    // A copy happens on an edge where busy is low and a commit is either new or outstanding.
    for (int n = 0; n < NUM_RCAS; n++) begin
      commit_hit_s[n] = accept_s & req_ok_s & (cfg_type == T_COMMIT) &
                        (cfg_rca_sel == RCA_SEL_W'(n));
      copy_s[n]       = ~rca_busy[n] & (pending_s[n] | commit_hit_s[n]);
    end
  end

  // Shadow bank field writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_src_r  <= '0;
      shadow_dst_r  <= '0;
      shadow_grid_r <= '0;
      shadow_io_r   <= '0;
      shadow_res_r  <= '0;
      shadow_use_r  <= '0;
    end else if (accept_s && req_ok_s) begin
      case (cfg_type)
        T_CPU: begin
          if (cfg_src_dest) begin
            shadow_dst_r[cfg_rca_sel][wp_idx_s] <= cfg_data[4:0];
          end else begin
            shadow_src_r[cfg_rca_sel][rp_idx_s] <= cfg_data[4:0];
          end
        end
        T_GRID:  shadow_grid_r[cfg_rca_sel][gm_idx_s] <= cfg_data[GRID_MUX_SEL_W-1:0];
        T_IO:    shadow_io_r[cfg_rca_sel][row_idx_s]  <= cfg_data[IO_MUX_SEL_W-1:0];
        T_RES:   shadow_res_r[cfg_rca_sel][wp_idx_s]  <= cfg_data[RES_SEL_W-1:0];
        T_USE:   shadow_use_r[cfg_rca_sel][row_idx_s] <= cfg_data[0];
        default: begin end
      endcase
    end
  end

  // Per-RCA commit tracker: IDLE -> PENDING on a commit while busy, back when busy drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_RCAS; n++) begin
        trk_r[n] <= TRK_IDLE;
      end
    end else begin
      for (int n = 0; n < NUM_RCAS; n++) begin
        case (trk_r[n])
          TRK_IDLE:    if (commit_hit_s[n] && rca_busy[n]) trk_r[n] <= TRK_PENDING;
          TRK_PENDING: if (!rca_busy[n]) trk_r[n] <= TRK_IDLE;
          default:     trk_r[n] <= TRK_IDLE;
        endcase
      end
    end
  end

  // Atomic shadow-to-active copy per RCA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_src_r  <= '0;
      active_dst_r  <= '0;
      active_grid_r <= '0;
      active_io_r   <= '0;
      active_res_r  <= '0;
      active_use_r  <= '0;
    end else begin
      for (int n = 0; n < NUM_RCAS; n++) begin
        if (copy_s[n]) begin
          active_src_r[n]  <= shadow_src_r[n];
          active_dst_r[n]  <= shadow_dst_r[n];
          active_grid_r[n] <= shadow_grid_r[n];
          active_io_r[n]   <= shadow_io_r[n];
          active_res_r[n]  <= shadow_res_r[n];
          active_use_r[n]  <= shadow_use_r[n];
        end
      end
    end
  end

  // One-cycle error pulse for accepted-but-rejected requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_error <= 1'b0;
    end else begin
      cfg_error <= accept_s & ~req_ok_s;
    end
  end

  assign src_reg_addrs  = active_src_r;
  assign dest_reg_addrs = active_dst_r;
  assign grid_mux_sel   = active_grid_r;
  assign io_mux_sel     = active_io_r;
  assign result_mux_sel = active_res_r;
  assign io_inp_use     = active_use_r;
  assign commit_pending = pending_s;

endmodule
